// File: rtl/instr_fetch_pkg.sv
// instr_fetch_pkg: shared fetch-state, register-number and format-detect constants
package instr_fetch_pkg;
    typedef enum logic [2:0] {
        FS_VEC,
        FS_OP,
        FS_SRC,
        FS_DST,
        FS_ISSUE
    } fetch_state_e;
    localparam logic [15:0] RESET_VEC_DEF = 16'hFFFE;
    localparam logic [3:0]  R0 = 4'd0;
    localparam logic [3:0]  R2 = 4'd2;
    localparam logic [3:0]  R3 = 4'd3;
    localparam logic [3:0]  FMT1_MIN = 4'd4;
    localparam logic [5:0]  FMT2_PFX = 6'b000100;
    localparam logic [2:0]  JMP_PFX  = 3'b001;
    localparam logic [1:0]  AS_IDX = 2'b01;
    localparam logic [1:0]  AS_INC = 2'b11;
endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: ROM read path, decoder handshake and redirect signals of the fetch unit
interface instr_fetch_if;
    logic [15:0] MDB_out;
    logic [15:0] MAB_fetch;
    logic        fetch_req;
    logic        dec_ready;
    logic        pc_load;
    logic [15:0] pc_new;
    logic        IR_valid;
    logic [15:0] IR_out;
    logic [15:0] SRC_EXT;
    logic [15:0] DST_EXT;
    logic [1:0]  IR_len;
    logic [15:0] pc_next;
    modport master (
        input  MDB_out, dec_ready, pc_load, pc_new,
        output MAB_fetch, fetch_req, IR_valid, IR_out, SRC_EXT, DST_EXT, IR_len, pc_next
    );
    modport slave (
        output MDB_out, dec_ready, pc_load, pc_new,
        input  MAB_fetch, fetch_req, IR_valid, IR_out, SRC_EXT, DST_EXT, IR_len, pc_next
    );
endinterface

// File: rtl/instr_fetch_len_dec.sv
// instr_len_dec: opcode -> extension-word needs; bit 6 (byte/word) never affects length
module instr_len_dec
    import instr_fetch_pkg::*;
(
    input  logic [15:7] i_op_hi,
    input  logic [5:0]  i_op_lo,
    output logic        o_need_src,
    output logic        o_need_dst
);
    logic       w_fmt1;
    logic       w_fmt2;
    logic [1:0] w_as;
    logic [3:0] w_sa;
    assign w_fmt1 = i_op_hi[15:12] >= FMT1_MIN;
    assign w_fmt2 = i_op_hi[15:10] == FMT2_PFX;
    assign w_as   = i_op_lo[5:4];
    assign w_sa   = w_fmt1 ? i_op_hi[11:8] : i_op_lo[3:0];
    assign o_need_src = (w_fmt1 || w_fmt2) &&
                        ((w_as == AS_IDX && w_sa != R3) || (w_as == AS_INC && w_sa == R0));
    assign o_need_dst = w_fmt1 && i_op_hi[7];
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: sequences opcode and extension-word reads and hands whole instructions to the decoder
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [15:0] RESET_VEC = RESET_VEC_DEF,
    parameter int          PC_W      = 16
)(
    input  logic          clk,
    input  logic          rst_n,
    instr_fetch_if.master bus
);
    fetch_state_e    r_state, w_state_nxt;
    logic [PC_W-1:0] r_pc, w_pc_nxt;
    logic [15:0]     r_ir, r_src, r_dst;
    logic [1:0]      r_len;
    logic            r_need_dst;
    logic            w_need_src, w_need_dst, w_redirect;

    instr_len_dec u_len_dec (
        .i_op_hi    (bus.MDB_out[15:7]),
        .i_op_lo    (bus.MDB_out[5:0]),
        .o_need_src (w_need_src),
        .o_need_dst (w_need_dst)
    );

    assign w_redirect = bus.pc_load && r_state != FS_VEC;

    // next state and next fetch address; a redirect overrides everything after the vector read
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        case (r_state)
            FS_VEC: begin
                w_state_nxt = FS_OP;
                w_pc_nxt    = PC_W'(bus.MDB_out & 16'hFFFE);
            end
            FS_OP: begin
                w_state_nxt = w_need_src ? FS_SRC : w_need_dst ? FS_DST : FS_ISSUE;
                w_pc_nxt    = r_pc + PC_W'(2);
            end
            FS_SRC: begin
                w_state_nxt = r_need_dst ? FS_DST : FS_ISSUE;
                w_pc_nxt    = r_pc + PC_W'(2);
            end
            FS_DST: begin
                w_state_nxt = FS_ISSUE;
                w_pc_nxt    = r_pc + PC_W'(2);
            end
            FS_ISSUE: w_state_nxt = bus.dec_ready ? FS_OP : FS_ISSUE;
            default:  w_state_nxt = FS_VEC;
        endcase
        if (w_redirect) begin
            w_state_nxt = FS_OP;
            w_pc_nxt    = PC_W'(bus.pc_new & 16'hFFFE);
        end
    end

    // state, PC and instruction word capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= FS_VEC;
            r_pc       <= PC_W'(RESET_VEC);
            r_ir       <= '0;
            r_src      <= '0;
            r_dst      <= '0;
            r_len      <= '0;
            r_need_dst <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            if (r_state == FS_OP) begin
                r_ir       <= bus.MDB_out;
                r_src      <= '0;
                r_dst      <= '0;
                r_need_dst <= w_need_dst;
                r_len      <= 2'd1 + 2'(w_need_src) + 2'(w_need_dst);
            end
            if (r_state == FS_SRC) r_src <= bus.MDB_out;
            if (r_state == FS_DST) r_dst <= bus.MDB_out;
        end
    end

    assign bus.MAB_fetch = 16'(r_pc);
    assign bus.fetch_req = rst_n && r_state != FS_ISSUE;
    assign bus.IR_valid  = r_state == FS_ISSUE;
    assign bus.IR_out    = r_ir;
    assign bus.SRC_EXT   = r_src;
    assign bus.DST_EXT   = r_dst;
    assign bus.IR_len    = r_len;
    assign bus.pc_next   = bus.IR_valid ? 16'(r_pc) : 16'h0000;
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed program through a ROM model, scoreboard-checked issued instructions
module tb_instr_fetch;
    typedef struct {
        logic [15:0] ir;
        logic [15:0] src;
        logic [15:0] dst;
        logic [1:0]  len;
        logic [15:0] pcn;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] rom [0:32767];
    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          n_done = 0;

    instr_fetch_if bus();

    instr_fetch #(.RESET_VEC(16'hFFFE), .PC_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.MDB_out = rom[bus.MAB_fetch[15:1]];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic put(input logic [15:0] addr, input logic [15:0] data);
        rom[addr[15:1]] = data;
    endtask

    task automatic push(input logic [15:0] ir, input logic [15:0] src, input logic [15:0] dst,
                        input logic [1:0] len, input logic [15:0] pcn);
        exp_t e;
        e.ir = ir; e.src = src; e.dst = dst; e.len = len; e.pcn = pcn;
        q.push_back(e);
    endtask

    // monitor: every accepted instruction is compared against the next expected one
    always @(negedge clk) begin
        if (rst_n && bus.IR_valid && bus.dec_ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_issue: got IR %h expected none", bus.IR_out);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("ir_out", bus.IR_out, e.ir);
                chk("src_ext", bus.SRC_EXT, e.src);
                chk("dst_ext", bus.DST_EXT, e.dst);
                chk("ir_len", {14'd0, bus.IR_len}, {14'd0, e.len});
                chk("pc_next", bus.pc_next, e.pcn);
            end
            n_done++;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit ok;
        for (int i = 0; i < 32768; i++) rom[i] = 16'h0000;
        put(16'hFFFE, 16'hC000);
        put(16'hC000, 16'h4506);
        put(16'hC002, 16'h4036); put(16'hC004, 16'h1234);
        put(16'hC006, 16'h4596); put(16'hC008, 16'h0002); put(16'hC00A, 16'h0004);
        put(16'hC00C, 16'h4226);
        put(16'hC00E, 16'h4316);
        put(16'hC010, 16'h3C05);
        put(16'hC012, 16'h4506);
        put(16'hC014, 16'h4036); put(16'hC016, 16'h1234);
        put(16'hD000, 16'h4506);
        put(16'hFFFC, 16'h4036);
        bus.dec_ready = 1'b1;
        bus.pc_load   = 1'b0;
        bus.pc_new    = 16'h0000;
        push(16'h4506, 16'h0000, 16'h0000, 2'd1, 16'hC002);
        push(16'h4036, 16'h1234, 16'h0000, 2'd2, 16'hC006);
        push(16'h4596, 16'h0002, 16'h0004, 2'd3, 16'hC00C);
        push(16'h4226, 16'h0000, 16'h0000, 2'd1, 16'hC00E);
        push(16'h4316, 16'h0000, 16'h0000, 2'd1, 16'hC010);
        push(16'h3C05, 16'h0000, 16'h0000, 2'd1, 16'hC012);
        @(negedge clk);
        @(negedge clk);
        chk("rst_ir_valid", {15'd0, bus.IR_valid}, 16'h0);
        chk("rst_ir_out", bus.IR_out, 16'h0);
        chk("rst_src_ext", bus.SRC_EXT, 16'h0);
        chk("rst_dst_ext", bus.DST_EXT, 16'h0);
        chk("rst_ir_len", {14'd0, bus.IR_len}, 16'h0);
        chk("rst_pc_next", bus.pc_next, 16'h0);
        chk("rst_mab", bus.MAB_fetch, 16'hFFFE);
        chk("rst_fetch_req", {15'd0, bus.fetch_req}, 16'h0);
        rst_n = 1'b1;
        #1;
        chk("vec_mab", bus.MAB_fetch, 16'hFFFE);
        chk("vec_fetch_req", {15'd0, bus.fetch_req}, 16'h1);
        chk("vec_ir_valid", {15'd0, bus.IR_valid}, 16'h0);
        @(posedge clk); #1;
        chk("op_mab", bus.MAB_fetch, 16'hC000);
        chk("op_ir_valid", {15'd0, bus.IR_valid}, 16'h0);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            if (n_done >= 6) begin ok = 1'b1; break; end
        end
        if (!ok) chk("wait_first6", 16'(n_done), 16'd6);
        #1;
        bus.dec_ready = 1'b0;
        push(16'h4506, 16'h0000, 16'h0000, 2'd1, 16'hC014);
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_ir_valid", {15'd0, bus.IR_valid}, 16'h1);
            chk("stall_fetch_req", {15'd0, bus.fetch_req}, 16'h0);
            chk("stall_mab", bus.MAB_fetch, 16'hC014);
            chk("stall_ir_out", bus.IR_out, 16'h4506);
            chk("stall_pc_next", bus.pc_next, 16'hC014);
            @(posedge clk);
        end
        #1;
        bus.dec_ready = 1'b1;
        @(posedge clk);
        chk("stall_release_count", 16'(n_done), 16'd7);
        @(posedge clk); #1;
        chk("src_mab", bus.MAB_fetch, 16'hC016);
        push(16'h4506, 16'h0000, 16'h0000, 2'd1, 16'hD002);
        bus.pc_load = 1'b1;
        bus.pc_new  = 16'hD001;
        @(posedge clk); #1;
        bus.pc_load = 1'b0;
        chk("redirect_mab", bus.MAB_fetch, 16'hD000);
        chk("redirect_ir_valid", {15'd0, bus.IR_valid}, 16'h0);
        @(posedge clk); #1;
        chk("d000_ir_valid", {15'd0, bus.IR_valid}, 16'h1);
        push(16'h4036, 16'hC000, 16'h0000, 2'd2, 16'h0000);
        push(16'h0000, 16'h0000, 16'h0000, 2'd1, 16'h0002);
        bus.pc_load = 1'b1;
        bus.pc_new  = 16'hFFFC;
        @(posedge clk); #1;
        bus.pc_load = 1'b0;
        chk("wrap_redirect_mab", bus.MAB_fetch, 16'hFFFC);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            if (n_done >= 10) begin ok = 1'b1; break; end
        end
        if (!ok) chk("wait_wrap", 16'(n_done), 16'd10);
        #1;
        bus.dec_ready = 1'b0;
        repeat (4) @(posedge clk);
        chk("queue_empty", 16'(q.size()), 16'd0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_mab", bus.MAB_fetch, 16'hFFFE);
        chk("midrst_fetch_req", {15'd0, bus.fetch_req}, 16'h0);
        chk("midrst_ir_valid", {15'd0, bus.IR_valid}, 16'h0);
        chk("midrst_ir_len", {14'd0, bus.IR_len}, 16'h0);
        @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
